// File: rtl/if_scratch_writer.sv
// Streams upstream beats into a circular scratch buffer and publishes a sliding window to a consumer.
// Optional 16-bit accepted-beat counter port beat_cnt when IFW_BEAT_CNT_EN is defined.
module if_scratch_writer #(
    parameter int ADDR_LEN      = 8,
    parameter int SCRATCH_DEPTH = 8,
    parameter int SCRATCH_WIDTH = 8,
    parameter int FILTER_SIZE   = 4,
    parameter int STRIDE        = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SCRATCH_WIDTH-1:0] in_data,
    input  logic                     in_last,
    output logic                     scr_wen,
    output logic [ADDR_LEN-1:0]      scr_waddr,
    output logic [SCRATCH_WIDTH-1:0] scr_din,
    output logic [ADDR_LEN-1:0]      win_base,
    output logic                     win_valid,
    input  logic                     slide,
    output logic                     row_done,
    output logic                     busy
`ifdef IFW_BEAT_CNT_EN
    ,
    output logic [15:0]              beat_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_LEN:0]   DEPTH_C   = (ADDR_LEN+1)'(SCRATCH_DEPTH);
    localparam logic [ADDR_LEN:0]   FILTER_C  = (ADDR_LEN+1)'(FILTER_SIZE);
    localparam logic [ADDR_LEN:0]   STRIDE_C  = (ADDR_LEN+1)'(STRIDE);
    localparam logic [ADDR_LEN-1:0] STRIDE_A  = ADDR_LEN'(STRIDE);
    localparam logic [ADDR_LEN-1:0] LAST_PTR  = ADDR_LEN'(SCRATCH_DEPTH - 1);
    localparam logic [ADDR_LEN-1:0] RD_WRAP_A = ADDR_LEN'(SCRATCH_DEPTH - STRIDE);

    state_t              state, state_nxt;
    logic [ADDR_LEN-1:0] wr_ptr, rd_ptr;
    logic [ADDR_LEN-1:0] wr_nxt, rd_nxt;
    logic [ADDR_LEN:0]   occ, occ_nxt;
    logic                accept, slide_ok;

    // Wrap compares against DEPTH-STRIDE so the sum never needs an extra bit.
    assign wr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    assign rd_nxt = (rd_ptr >= RD_WRAP_A) ? rd_ptr - RD_WRAP_A : rd_ptr + STRIDE_A;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        win_valid = 1'b0;
        row_done  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = FILL;
            end
            FILL: begin
                in_ready  = (occ != DEPTH_C);
                win_valid = (occ >= FILTER_C);
            end
            DRAIN: begin
                win_valid = (occ >= FILTER_C);
            end
            DONE: begin
                row_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        accept   = in_valid & in_ready;
        slide_ok = slide & win_valid;
        occ_nxt  = occ + {{ADDR_LEN{1'b0}}, accept} - (slide_ok ? STRIDE_C : '0);

        if (state == FILL && accept && in_last)
            state_nxt = DRAIN;
        if (state == DRAIN && occ_nxt < FILTER_C)
            state_nxt = DONE;
    end

    assign scr_wen   = accept;
    assign scr_waddr = wr_ptr;
    assign scr_din   = in_data;
    assign win_base  = rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end
        end else begin
            if (accept)
                wr_ptr <= wr_nxt;
            if (slide_ok)
                rd_ptr <= rd_nxt;
            occ <= occ_nxt;
        end
    end

`ifdef IFW_BEAT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            beat_cnt <= '0;
        else if (state == IDLE && start)
            beat_cnt <= '0;
        else if (accept && beat_cnt != 16'hFFFF)
            beat_cnt <= beat_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_if_scratch_writer.sv
// Directed bench: u0 uses default parameters, u1 uses SCRATCH_DEPTH=6, STRIDE=2.
module tb_if_scratch_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, in_valid = 1'b0, in_last = 1'b0, slide = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       u0_rdy, u0_wen, u0_wv, u0_done, u0_busy;
    logic [7:0] u0_waddr, u0_din, u0_base;
    logic       u1_rdy, u1_wen, u1_wv, u1_done, u1_busy;
    logic [7:0] u1_waddr, u1_din, u1_base;
`ifdef IFW_BEAT_CNT_EN
    logic [15:0] u0_bc, u1_bc;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_scratch_writer u0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(u0_rdy),
        .in_data(in_data), .in_last(in_last), .scr_wen(u0_wen), .scr_waddr(u0_waddr),
        .scr_din(u0_din), .win_base(u0_base), .win_valid(u0_wv), .slide(slide),
        .row_done(u0_done), .busy(u0_busy)
`ifdef IFW_BEAT_CNT_EN
        , .beat_cnt(u0_bc)
`endif
    );

    if_scratch_writer #(.SCRATCH_DEPTH(6), .STRIDE(2)) u1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(u1_rdy),
        .in_data(in_data), .in_last(in_last), .scr_wen(u1_wen), .scr_waddr(u1_waddr),
        .scr_din(u1_din), .win_base(u1_base), .win_valid(u1_wv), .slide(slide),
        .row_done(u1_done), .busy(u1_busy)
`ifdef IFW_BEAT_CNT_EN
        , .beat_cnt(u1_bc)
`endif
    );

    typedef struct {
        logic       st, vld;
        logic [7:0] dat;
        logic       lst, sld;
        logic       e_rdy, e_wen;
        logic [7:0] e_waddr;
        logic       e_wv;
        logic [7:0] e_base;
        logic       e_done, e_busy;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic st, input logic vld, input logic [7:0] dat,
                         input logic lst, input logic sld);
        start    = st;
        in_valid = vld;
        in_data  = dat;
        in_last  = lst;
        slide    = sld;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    int pulses;

    initial begin
        // Row of 6 beats on u0, drained by three single-entry slides.
        //           st   vld  dat    lst  sld    rdy  wen  waddr  wv   base   done busy
        tbl[0]  = '{1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'd0,1'b0,8'd0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'd0,1'b0,8'd0,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b1,8'h11,1'b0,1'b0, 1'b1,1'b1,8'd0,1'b0,8'd0,1'b0,1'b1};
        tbl[3]  = '{1'b0,1'b1,8'h12,1'b0,1'b1, 1'b1,1'b1,8'd1,1'b0,8'd0,1'b0,1'b1};
        tbl[4]  = '{1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'd2,1'b0,8'd0,1'b0,1'b1};
        tbl[5]  = '{1'b0,1'b1,8'h13,1'b0,1'b0, 1'b1,1'b1,8'd2,1'b0,8'd0,1'b0,1'b1};
        tbl[6]  = '{1'b0,1'b1,8'h14,1'b0,1'b0, 1'b1,1'b1,8'd3,1'b0,8'd0,1'b0,1'b1};
        tbl[7]  = '{1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'd4,1'b1,8'd0,1'b0,1'b1};
        tbl[8]  = '{1'b0,1'b1,8'h15,1'b0,1'b0, 1'b1,1'b1,8'd4,1'b1,8'd0,1'b0,1'b1};
        tbl[9]  = '{1'b0,1'b1,8'h16,1'b1,1'b0, 1'b1,1'b1,8'd5,1'b1,8'd0,1'b0,1'b1};
        tbl[10] = '{1'b0,1'b1,8'h17,1'b0,1'b1, 1'b0,1'b0,8'd6,1'b1,8'd0,1'b0,1'b1};
        tbl[11] = '{1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,8'd6,1'b1,8'd1,1'b0,1'b1};
        tbl[12] = '{1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,8'd6,1'b1,8'd2,1'b0,1'b1};
        tbl[13] = '{1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'd6,1'b0,8'd3,1'b1,1'b1};
        tbl[14] = '{1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'd6,1'b0,8'd3,1'b0,1'b0};

        // Outputs while reset is held, with in_valid and start asserted.
        drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1);
        #3;
        check("rst_rdy",   32'(u0_rdy),   32'd0);
        check("rst_wen",   32'(u0_wen),   32'd0);
        check("rst_waddr", 32'(u0_waddr), 32'd0);
        check("rst_wv",    32'(u0_wv),    32'd0);
        check("rst_base",  32'(u0_base),  32'd0);
        check("rst_done",  32'(u0_done),  32'd0);
        check("rst_busy",  32'(u0_busy),  32'd0);
        @(negedge clk);
        do_reset();

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].vld, tbl[i].dat, tbl[i].lst, tbl[i].sld);
            #1;
            check($sformatf("v%0d_rdy", i),   32'(u0_rdy),   32'(tbl[i].e_rdy));
            check($sformatf("v%0d_wen", i),   32'(u0_wen),   32'(tbl[i].e_wen));
            check($sformatf("v%0d_waddr", i), 32'(u0_waddr), 32'(tbl[i].e_waddr));
            check($sformatf("v%0d_din", i),   32'(u0_din),   32'(tbl[i].dat));
            check($sformatf("v%0d_wv", i),    32'(u0_wv),    32'(tbl[i].e_wv));
            check($sformatf("v%0d_base", i),  32'(u0_base),  32'(tbl[i].e_base));
            check($sformatf("v%0d_done", i),  32'(u0_done),  32'(tbl[i].e_done));
            check($sformatf("v%0d_busy", i),  32'(u0_busy),  32'(tbl[i].e_busy));
            step();
        end

        // Fill u0 to capacity, then release one entry while upstream keeps offering.
        do_reset();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        for (int b = 0; b < 8; b++) begin
            drive(1'b0, 1'b1, 8'(8'h20 + b), 1'b0, 1'b0);
            #1;
            check($sformatf("full_wen%0d", b),   32'(u0_wen),   32'd1);
            check($sformatf("full_waddr%0d", b), 32'(u0_waddr), 32'(b));
            step();
        end
        #1;
        check("full_rdy",  32'(u0_rdy), 32'd0);
        check("full_wen",  32'(u0_wen), 32'd0);
        check("full_wv",   32'(u0_wv),  32'd1);
        slide = 1'b1;
        #1;
        check("full_slide_rdy", 32'(u0_rdy), 32'd0);
        step();
        slide = 1'b0;
        #1;
        check("after_slide_rdy",   32'(u0_rdy),   32'd1);
        check("after_slide_base",  32'(u0_base),  32'd1);
        check("after_slide_waddr", 32'(u0_waddr), 32'd0);

        // u1: depth 6, stride 2; nine beats with slides from beat 5 onward.
        do_reset();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        for (int b = 1; b <= 9; b++) begin
            drive(1'b0, 1'b1, 8'(b), (b == 9), (b >= 5));
            #1;
            check($sformatf("d6_wen%0d", b),   32'(u1_wen),   32'd1);
            check($sformatf("d6_waddr%0d", b), 32'(u1_waddr), 32'((b - 1) % 6));
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        check("d6_base_wrap", 32'(u1_base), 32'd0);
        check("d6_wv_drain",  32'(u1_wv),   32'd0);
        check("d6_busy",      32'(u1_busy), 32'd1);
        step();
        check("d6_done",      32'(u1_done), 32'd1);
        step();
        check("d6_idle_busy", 32'(u1_busy), 32'd0);
        check("d6_idle_done", 32'(u1_done), 32'd0);

        // u1: accept and stride-2 slide together at occupancy 4.
        do_reset();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        for (int b = 0; b < 4; b++) begin
            drive(1'b0, 1'b1, 8'(8'h40 + b), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 8'h44, 1'b0, 1'b1);
        #1;
        check("s2_wv_pre",  32'(u1_wv),  32'd1);
        check("s2_wen_pre", 32'(u1_wen), 32'd1);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        check("s2_wv_post",   32'(u1_wv),    32'd0);
        check("s2_base_post", 32'(u1_base),  32'd2);
        check("s2_rdy_post",  32'(u1_rdy),   32'd1);
        check("s2_waddr",     32'(u1_waddr), 32'd5);

        // u0: asynchronous reset mid-row at occupancy 5.
        do_reset();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        for (int b = 0; b < 5; b++) begin
            drive(1'b0, 1'b1, 8'(8'h60 + b), 1'b0, 1'b0);
            step();
        end
        #1;
        check("pre_arst_wv", 32'(u0_wv), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_rdy",   32'(u0_rdy),   32'd0);
        check("arst_wen",   32'(u0_wen),   32'd0);
        check("arst_waddr", 32'(u0_waddr), 32'd0);
        check("arst_base",  32'(u0_base),  32'd0);
        check("arst_wv",    32'(u0_wv),    32'd0);
        check("arst_busy",  32'(u0_busy),  32'd0);
        check("arst_done",  32'(u0_done),  32'd0);
`ifdef IFW_BEAT_CNT_EN
        check("arst_bcnt",  32'(u0_bc),    32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (u0_done) pulses++;
            step();
        end
        check("arst_no_row_done", 32'(pulses), 32'd0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 8'h70, 1'b0, 1'b0);
        #1;
        check("restart_waddr", 32'(u0_waddr), 32'd0);
        check("restart_wen",   32'(u0_wen),   32'd1);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_scratch_writer.md
IF_SCRATCH_WRITER -- requirements
Module: if_scratch_writer

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 8, scratch address width.
REQ-002 SHALL have parameter SCRATCH_DEPTH, default 8, circular buffer entries; legal range 2..2^ADDR_LEN.
REQ-003 SHALL have parameter SCRATCH_WIDTH, default 8, data word width.
REQ-004 SHALL have parameter FILTER_SIZE, default 4, window length; legal range 1..SCRATCH_DEPTH.
REQ-005 SHALL have parameter STRIDE, default 1, entries released per slide; legal range 1..FILTER_SIZE.
REQ-006 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port start  input  1  begin new row; honoured only in IDLE.
REQ-009 SHALL have port in_valid  input  1  upstream beat valid.
REQ-010 SHALL have port in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-011 SHALL have port in_data  input  SCRATCH_WIDTH  upstream word.
REQ-012 SHALL have port in_last  input  1  marks final beat of row.
REQ-013 SHALL have port scr_wen  output  1  scratch write enable.
REQ-014 SHALL have port scr_waddr  output  ADDR_LEN  scratch write address.
REQ-015 SHALL have port scr_din  output  SCRATCH_WIDTH  scratch write data.
REQ-016 SHALL have port win_base  output  ADDR_LEN  scratch address of oldest held entry.
REQ-017 SHALL have port win_valid  output  1  FILTER_SIZE entries available from win_base.
REQ-018 SHALL have port slide  input  1  consumer releases STRIDE entries.
REQ-019 SHALL have port row_done  output  1  one-cycle pulse at row completion.
REQ-020 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, FILL, DRAIN, DONE.
REQ-022 IDLE: in_ready=0; start -> FILL, clearing wr_ptr, rd_ptr, occupancy to 0 on the same edge.
REQ-023 FILL: in_ready = (occupancy != SCRATCH_DEPTH); accepted beat with in_last=1 -> DRAIN.
REQ-024 DRAIN: in_ready=0; when occupancy < FILTER_SIZE after update -> DONE.
REQ-025 DONE: row_done=1 for exactly this one cycle; unconditional -> IDLE.
REQ-026 scr_wen = in_valid & in_ready, combinational, zero latency; scr_waddr = wr_ptr; scr_din = in_data.
REQ-027 Accepted beat SHALL advance wr_ptr by 1, wrapping from SCRATCH_DEPTH-1 to 0 (non-power-of-2 depth supported).
REQ-028 win_valid = (occupancy >= FILTER_SIZE) in FILL or DRAIN, else 0; win_base = rd_ptr.
REQ-029 slide with win_valid=1 SHALL advance rd_ptr by STRIDE modulo SCRATCH_DEPTH and reduce occupancy by STRIDE; slide with win_valid=0 SHALL be ignored.
REQ-030 Simultaneous accept and honoured slide SHALL update occupancy by +1-STRIDE in one cycle.
REQ-031 Full (occupancy == SCRATCH_DEPTH): in_ready=0 same cycle; a slide that cycle re-enables in_ready next cycle.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 occupancy SHALL be ADDR_LEN+1 bits wide and never exceed SCRATCH_DEPTH or underflow.

Reset
REQ-034 rst SHALL force state IDLE, wr_ptr=0, rd_ptr=0, occupancy=0 immediately, regardless of clk.
REQ-035 During and after reset: in_ready=0, scr_wen=0, scr_waddr=0, win_base=0, win_valid=0, row_done=0, busy=0.
REQ-036 rst mid-row SHALL discard all held entries; no row_done pulse SHALL be produced for the aborted row.

Configuration
REQ-037 With macro IFW_BEAT_CNT_EN defined, SHALL add output beat_cnt (16 bits): cleared by rst and by honoured start, +1 per accepted beat, saturating at 16'hFFFF.
REQ-038 Without IFW_BEAT_CNT_EN, port beat_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-039 Defaults; start, stream 4 beats 0x11..0x14 (last on 4th) -> scr_waddr 0..3, win_valid=1 after 4th accept, win_base=0.
REQ-040 Defaults; 8 beats no slide -> in_ready=0 after 8th accept, occupancy 8; one slide -> in_ready=1 next cycle, win_base=1.
REQ-041 SCRATCH_DEPTH=6; stream 9 beats with slides from beat 5 -> scr_waddr sequence 0,1,2,3,4,5,0,1,2, no overflow.
REQ-042 Defaults; in_last on 6th beat, then 3 slides -> DONE after 3rd slide (occupancy 3), row_done exactly one cycle, then IDLE, busy=0.
REQ-043 Accept and slide same cycle at occupancy 4, STRIDE=2 -> occupancy 3 next cycle, win_valid=0.
REQ-044 rst asserted mid-FILL at occupancy 5 -> all outputs at reset values before next clk edge; IFW_BEAT_CNT_EN build: beat_cnt=0.
